systolic_skew_feeder: RTL and testbench

- Upstream stage of the systolic array.
- Accepts one unskewed operand beat per cycle: one A column (ARR_HEIGHT elements) and one B row (ARR_WIDTH elements).
- Applies the diagonal skew the array needs: row i is delayed i cycles, column j is delayed j cycles.
- After the last beat of a tile it drains the pipeline, then pulses the array's done flag.

---
 rtl/systolic_pkg.sv | 22 ++
 rtl/skew_delay_line.sv | 25 ++
 rtl/systolic_skew_feeder.sv | 127 ++++++++++++
 tb/tb_systolic_skew_feeder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array front end.
package systolic_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

    localparam logic [DEFAULT_WIDTH-1:0] ZERO_ELEM = '0;

    // Cycles needed for the last diagonal to pass the far PE, plus PE latency.
    function automatic int unsigned drain_cycles(input int unsigned h,
                                                 input int unsigned w,
                                                 input int unsigned lat);
        return h + w - 1 + lat;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage shift register; one instance per skewed array lane.
module skew_delay_line #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(DEPTH); k++) stage[k] <= '0;
        end else begin
            stage[0] <= din;
            for (int k = 1; k < int'(DEPTH); k++) stage[k] <= stage[k-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews unskewed A/B operand beats onto the array edges and signals tile completion.
// Optional beat counter output enabled by defining SKEW_FEEDER_BEAT_CNT_EN.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ARR_HEIGHT = 4,
    parameter int unsigned ARR_WIDTH  = 4,
    parameter int unsigned PE_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ARR_HEIGHT*WIDTH-1:0] in_a,
    input  logic [ARR_WIDTH*WIDTH-1:0]  in_b,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [ARR_HEIGHT*WIDTH-1:0] out_a,
    output logic [ARR_WIDTH*WIDTH-1:0]  out_b,
    output logic                        out_done_flag,
`ifdef SKEW_FEEDER_BEAT_CNT_EN
    output logic [15:0]                 beat_count,
`endif
    output logic                        busy
);

    localparam int unsigned CNT_W = $clog2(ARR_HEIGHT + ARR_WIDTH + PE_LATENCY) + 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD =
        CNT_W'(drain_cycles(ARR_HEIGHT, ARR_WIDTH, PE_LATENCY));

    feeder_state_t    state;
    logic [CNT_W-1:0] drain_cnt;
    logic             ready_q;
    logic             done_q;
    logic             busy_q;
    logic             accept;

    // Ready is held low for as long as reset is asserted.
    assign in_ready      = ready_q & ~reset;
    assign accept        = in_valid & in_ready;
    assign out_done_flag = done_q;
    assign busy          = busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, STREAM: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (in_last) begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                            ready_q   <= 1'b0;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - CNT_W'(1);
                    if (drain_cnt == CNT_W'(1)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Lane i of A / lane j of B gets i+1 / j+1 stages; bubbles inject zero.
    for (genvar i = 0; i < int'(ARR_HEIGHT); i++) begin : g_a_lane
        logic [WIDTH-1:0] head;
        assign head = accept ? in_a[i*WIDTH +: WIDTH] : WIDTH'(ZERO_ELEM);
        skew_delay_line #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_dl (
            .clk   (clk),
            .reset (reset),
            .din   (head),
            .dout  (out_a[i*WIDTH +: WIDTH])
        );
    end

    for (genvar j = 0; j < int'(ARR_WIDTH); j++) begin : g_b_lane
        logic [WIDTH-1:0] head;
        assign head = accept ? in_b[j*WIDTH +: WIDTH] : WIDTH'(ZERO_ELEM);
        skew_delay_line #(.WIDTH(WIDTH), .DEPTH(j + 1)) u_dl (
            .clk   (clk),
            .reset (reset),
            .din   (head),
            .dout  (out_b[j*WIDTH +: WIDTH])
        );
    end

`ifdef SKEW_FEEDER_BEAT_CNT_EN
    logic [15:0] beat_cnt_q;

    // Cleared when leaving DONE so the next tile starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt_q <= '0;
        end else if (state == DONE) begin
            beat_cnt_q <= '0;
        end else if (accept && beat_cnt_q != 16'hFFFF) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
        end
    end

    assign beat_count = beat_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder against a cycle-indexed history model.
module tb_systolic_skew_feeder;

    localparam int unsigned W  = 16;
    localparam int unsigned H  = 4;
    localparam int unsigned AW = 4;
    localparam int          D  = 8;   // H + AW - 1 + PE_LATENCY

    logic            clk;
    logic            reset;
    logic [H*W-1:0]  in_a;
    logic [AW*W-1:0] in_b;
    logic            in_valid;
    logic            in_last;
    logic            in_ready;
    logic [H*W-1:0]  out_a;
    logic [AW*W-1:0] out_b;
    logic            out_done_flag;
    logic            busy;
`ifdef SKEW_FEEDER_BEAT_CNT_EN
    logic [15:0]     beat_count;
`endif

    systolic_skew_feeder #(
        .WIDTH(W), .ARR_HEIGHT(H), .ARR_WIDTH(AW), .PE_LATENCY(1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .out_a         (out_a),
        .out_b         (out_b),
        .out_done_flag (out_done_flag),
`ifdef SKEW_FEEDER_BEAT_CNT_EN
        .beat_count    (beat_count),
`endif
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int passes = 0;
    int checks = 0;

    // Reference model: per-edge value injected at the array edge, plus tile timing.
    logic [H*W-1:0]  hist_a [0:4095];
    logic [AW*W-1:0] hist_b [0:4095];
    int          n          = 0;
    int          reset_idx  = 0;
    int          last_edge  = -1000;
    bit          streaming  = 1'b0;
    bit          m_ready    = 1'b1;
    logic [15:0] m_cnt      = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] exp_a(input int i);
        int idx = n - i;
        if (idx <= reset_idx) return '0;
        return hist_a[idx][i*W +: W];
    endfunction

    function automatic logic [W-1:0] exp_b(input int j);
        int idx = n - j;
        if (idx <= reset_idx) return '0;
        return hist_b[idx][j*W +: W];
    endfunction

    task automatic check_outputs();
        bit in_tile;
        in_tile = (n >= last_edge) && (n <= last_edge + D);
        for (int i = 0; i < int'(H); i++)
            check($sformatf("out_a[%0d]@%0d", i, n), 32'(out_a[i*W +: W]), 32'(exp_a(i)));
        for (int j = 0; j < int'(AW); j++)
            check($sformatf("out_b[%0d]@%0d", j, n), 32'(out_b[j*W +: W]), 32'(exp_b(j)));
        check($sformatf("done@%0d", n), 32'(out_done_flag), 32'(n == last_edge + D));
        check($sformatf("busy@%0d", n), 32'(busy), 32'(streaming || in_tile));
        check($sformatf("ready@%0d", n), 32'(in_ready), 32'(m_ready));
`ifdef SKEW_FEEDER_BEAT_CNT_EN
        check($sformatf("beat_count@%0d", n), 32'(beat_count), 32'(m_cnt));
`endif
    endtask

    task automatic step(input logic v, input logic l, input logic [H*W-1:0] a,
                        input logic [AW*W-1:0] b, output bit acc);
        in_valid = v;
        in_last  = l;
        in_a     = a;
        in_b     = b;
        acc      = v && m_ready;
        @(posedge clk);
        n++;
        if (n == last_edge + D + 1) m_cnt = '0;
        hist_a[n] = acc ? a : '0;
        hist_b[n] = acc ? b : '0;
        if (acc) begin
            if (m_cnt != 16'hFFFF) m_cnt++;
            if (l) begin
                last_edge = n;
                streaming = 1'b0;
            end else begin
                streaming = 1'b1;
            end
        end
        m_ready = !((n >= last_edge) && (n <= last_edge + D));
        #1;
        check_outputs();
    endtask

    // Hold one beat valid until the model says it was taken.
    task automatic send(input logic l, input logic [H*W-1:0] a, input logic [AW*W-1:0] b,
                        output int acc_edge);
        bit acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) step(1'b1, l, a, b, acc);
        check("send_accept", 32'(acc), 32'd1);
        acc_edge = n;
    endtask

    task automatic idle(input int cycles);
        bit acc;
        for (int k = 0; k < cycles; k++) step(1'b0, 1'b0, '0, '0, acc);
    endtask

    function automatic logic [H*W-1:0] rnd_a();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [AW*W-1:0] rnd_b();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        streaming = 1'b0;
        last_edge = -1000;
        m_ready   = 1'b1;
        m_cnt     = '0;
        reset_idx = n;
    endtask

    initial begin
        int  t;
        int  last_acc;
        int  first_next;
        bit  acc;
        logic [H*W-1:0]  a1;
        logic [AW*W-1:0] b1;

        // Reset asserted with a valid beat presented.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_a     = rnd_a();
        in_b     = rnd_b();
        #3;
        check("rst_out_a", 32'(out_a != '0), 32'd0);
        check("rst_out_b", 32'(out_b != '0), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(out_done_flag), 32'd0);
        #20;
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Single-beat tile with recognisable lane values.
        a1 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        b1 = {16'h0014, 16'h0013, 16'h0012, 16'h0011};
        send(1'b1, a1, b1, t);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < int'(H); i++)
                check($sformatf("skew_a[%0d]+%0d", i, n - t), 32'(out_a[i*W +: W]),
                      (n - t == i) ? 32'(16'h0001 + i) : 32'd0);
            for (int j = 0; j < int'(AW); j++)
                check($sformatf("skew_b[%0d]+%0d", j, n - t), 32'(out_b[j*W +: W]),
                      (n - t == j) ? 32'(16'h0011 + j) : 32'd0);
            step(1'b0, 1'b0, '0, '0, acc);
        end
        idle(6);

        // Four-beat tile then drain to done.
        for (int k = 0; k < 4; k++) send(k == 3, rnd_a(), rnd_b(), last_acc);
        idle(D + 3);

        // Tile with a bubble in the middle.
        send(1'b0, rnd_a(), rnd_b(), t);
        send(1'b0, rnd_a(), rnd_b(), t);
        idle(1);
        send(1'b0, rnd_a(), rnd_b(), t);
        send(1'b1, rnd_a(), rnd_b(), last_acc);
        idle(D + 3);

        // Backpressure: next tile's first beat held valid through drain.
        for (int k = 0; k < 4; k++) send(k == 3, rnd_a(), rnd_b(), last_acc);
        send(1'b0, rnd_a(), rnd_b(), first_next);
        check("bp_first_accept_edge", 32'(first_next - last_acc), 32'(D + 2));
        for (int k = 1; k < 5; k++) send(k == 4, rnd_a(), rnd_b(), last_acc);
        step(1'b0, 1'b0, '0, '0, acc);
`ifdef SKEW_FEEDER_BEAT_CNT_EN
        check("beat_count_drain", 32'(beat_count), 32'd5);
`endif
        idle(D + 2);
`ifdef SKEW_FEEDER_BEAT_CNT_EN
        check("beat_count_after_done", 32'(beat_count), 32'd0);
`endif

        // Asynchronous reset in the middle of a tile.
        for (int k = 0; k < 3; k++) send(1'b0, rnd_a(), rnd_b(), t);
        in_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_a", 32'(out_a != '0), 32'd0);
        check("midrst_out_b", 32'(out_b != '0), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        #3;
        repeat (2) @(posedge clk);
        check("midrst_done", 32'(out_done_flag), 32'd0);
        #3;
        reset    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1;
        check("midrst_release_ready", 32'(in_ready), 32'd1);
        idle(D + 3);

        // Randomised traffic with bubbles and random tile lengths.
        for (int k = 0; k < 300; k++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, rnd_a(), rnd_b(), acc);
        idle(D + 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
